// File: rtl/wb_stage_if.sv
// rtl/wb_stage_if.sv - MEM-to-WB instruction handoff bus
interface wb_stage_if #(
    parameter int DW = 16,
    parameter int AW = 4
);
    logic          in_valid;
    logic          in_ready;
    logic [AW-1:0] in_dst;
    logic          in_wen;
    logic          in_is_load;
    logic [DW-1:0] in_alu_data;
    logic          in_halt;

    // MEM stage side: presents instructions
    modport master (
        output in_valid, in_dst, in_wen, in_is_load, in_alu_data, in_halt,
        input  in_ready
    );

    // WB stage side: accepts instructions
    modport slave (
        input  in_valid, in_dst, in_wen, in_is_load, in_alu_data, in_halt,
        output in_ready
    );
endinterface

// File: rtl/wb_stage.sv
// rtl/wb_stage.sv - writeback stage: one MEM/WB entry, load wait, retire count, halt latch
module wb_stage #(
    parameter int DW = 16,
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          rst,
    wb_stage_if.slave     mem,
    input  logic          ld_valid,
    input  logic [DW-1:0] ld_data,
    output logic [AW-1:0] DstReg,
    output logic          WriteReg,
    output logic [DW-1:0] DstData,
    output logic [15:0]   retire_count,
    output logic          halted
);

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        READY   = 2'd1,
        WAIT_LD = 2'd2,
        HALTED  = 2'd3
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [AW-1:0] entry_dst;
    logic          entry_wen;
    logic          entry_halt;
    logic [DW-1:0] entry_data;
    logic          ready;
    logic          accept;

    // A retiring HLT blocks the next accept so nothing follows it into the entry
    assign ready  = (state == EMPTY) || (state == READY && !entry_halt);
    assign accept = mem.in_valid && ready;

    assign mem.in_ready = ready;
    assign DstReg       = entry_dst;
    assign DstData      = entry_data;
    assign WriteReg     = (state == READY) && entry_wen && (entry_dst != '0);
    assign halted       = (state == HALTED);

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= EMPTY;
        end else begin
            state <= state_next;
        end
    end

    // Next-state: READY lasts exactly one cycle, refilled back-to-back when possible
    always_comb begin
        state_next = state;
        case (state)
            EMPTY: begin
                if (accept) begin
                    state_next = mem.in_is_load ? WAIT_LD : READY;
                end
            end
            READY: begin
                if (entry_halt) begin
                    state_next = HALTED;
                end else if (accept) begin
                    state_next = mem.in_is_load ? WAIT_LD : READY;
                end else begin
                    state_next = EMPTY;
                end
            end
            WAIT_LD: begin
                if (ld_valid) begin
                    state_next = READY;
                end
            end
            HALTED: begin
                state_next = HALTED;
            end
            default: begin
                state_next = EMPTY;
            end
        endcase
    end

    // Entry capture: control on accept, data from ALU now or from the cache later
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            entry_dst  <= '0;
            entry_wen  <= 1'b0;
            entry_halt <= 1'b0;
            entry_data <= '0;
        end else if (accept) begin
            entry_dst  <= mem.in_dst;
            entry_wen  <= mem.in_wen;
            entry_halt <= mem.in_halt;
            if (!mem.in_is_load) begin
                entry_data <= mem.in_alu_data;
            end
        end else if (state == WAIT_LD && ld_valid) begin
            entry_data <= ld_data;
        end
    end

    // Every READY cycle retires one instruction, wrapping at 16 bits
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            retire_count <= 16'h0000;
        end else if (state == READY) begin
            retire_count <= retire_count + 16'd1;
        end
    end

endmodule
